mux_scan: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer with a manual-select mode and an automatic round-robin scan mode that skips masked channels. It is the next-generation selector for the LFSR/datapath assignments: it replaces single-bit 2:1 muxes wherever several multi-bit sources must be sampled in turn. Each capture also registers the source channel number and a one-cycle valid strobe.

---
 rtl/mux_scan_if.sv | 27 ++
 rtl/mux_scan.sv | 118 +++++++++++
 tb/tb_mux_scan.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// Bus bundle for mux_scan: capture controls and channel data in, registered selection out.
// The master drives the controls and data. The slave (the selector) returns the captured sample.
interface mux_scan_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
);
   logic                      en;
   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [CHANNELS-1:0]       skip_mask;
   logic [CHANNELS*WIDTH-1:0] din;
   logic [WIDTH-1:0]          dout;
   logic [SEL_W-1:0]          dout_ch;
   logic                      dout_valid;
   logic                      scan_wrap;

   modport master (
      output en, mode, sel, skip_mask, din,
      input  dout, dout_ch, dout_valid, scan_wrap
   );

   modport slave (
      input  en, mode, sel, skip_mask, din,
      output dout, dout_ch, dout_valid, scan_wrap
   );
endinterface

// File: rtl/mux_scan.sv
// mux_scan: registered N-channel selector with a manual select mode and a masked round-robin scan.
// Every capture registers the data, its channel number and a one-cycle valid strobe.
module mux_scan #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   mux_scan_if.slave bus
);
   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] ch;
      logic             wrap;
   } pick_t;

   logic [WIDTH-1:0] ch_data [CHANNELS];

   logic [WIDTH-1:0] dout_p1;
   logic [SEL_W-1:0] ch_p1;
   logic             vld_p1;
   logic             wrap_p1;
   logic [SEL_W-1:0] ptr_p1;

   pick_t            pick_p0;
   logic             sel_ok_p0;
   logic             cap_p0;
   logic [SEL_W-1:0] cap_ch_p0;
   logic             wrap_p0;
   logic [SEL_W-1:0] ptr_nxt_p0;

   // An out-of-range pointer restarts the scan at channel 0.
   function automatic logic [SEL_W-1:0] norm_ptr(input logic [SEL_W-1:0] p);
      if ({1'b0, p} >= (SEL_W+1)'(CHANNELS)) return '0;
      return p;
   endfunction

   function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
      if ({1'b0, c} == (SEL_W+1)'(CHANNELS - 1)) return '0;
      return c + 1'b1;
   endfunction

   // First unmasked channel at or after start (circular). wrap is set when that
   // channel is the highest unmasked one, i.e. it closes the current lap.
   function automatic pick_t scan_pick(input logic [SEL_W-1:0]    start,
                                       input logic [CHANNELS-1:0] mask);
      pick_t          r;
      logic [SEL_W:0] sum;
      logic [SEL_W-1:0] idx;
      r = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sum = {1'b0, start} + (SEL_W+1)'(i);
         if (sum >= (SEL_W+1)'(CHANNELS)) sum = sum - (SEL_W+1)'(CHANNELS);
         idx = sum[SEL_W-1:0];
         if (!r.found && !mask[idx]) begin
            r.found = 1'b1;
            r.ch    = idx;
         end
      end
      r.wrap = r.found;
      for (int k = 0; k < CHANNELS; k++) begin
         if (!mask[k] && ((SEL_W+1)'(k) > {1'b0, r.ch})) r.wrap = 1'b0;
      end
      return r;
   endfunction

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign ch_data[k] = bus.din[k*WIDTH +: WIDTH];
   end

   // Stage p0: decide what (if anything) is captured this cycle.
   always_comb begin
      pick_p0    = scan_pick(norm_ptr(ptr_p1), bus.skip_mask);
      sel_ok_p0  = ({1'b0, bus.sel} < (SEL_W+1)'(CHANNELS));
      cap_p0     = 1'b0;
      cap_ch_p0  = '0;
      wrap_p0    = 1'b0;
      ptr_nxt_p0 = ptr_p1;
      if (bus.en) begin
         if (bus.mode) begin
            if (pick_p0.found) begin
               cap_p0     = 1'b1;
               cap_ch_p0  = pick_p0.ch;
               wrap_p0    = pick_p0.wrap;
               ptr_nxt_p0 = next_ch(pick_p0.ch);
            end
         end else if (sel_ok_p0) begin
            cap_p0    = 1'b1;
            cap_ch_p0 = bus.sel;
         end
      end
   end

   // Stage p1: registered outputs and scan pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_p1 <= '0;
         ch_p1   <= '0;
         vld_p1  <= 1'b0;
         wrap_p1 <= 1'b0;
         ptr_p1  <= '0;
      end else begin
         vld_p1  <= cap_p0;
         wrap_p1 <= wrap_p0;
         ptr_p1  <= ptr_nxt_p0;
         if (cap_p0) begin
            dout_p1 <= ch_data[cap_ch_p0];
            ch_p1   <= cap_ch_p0;
         end
      end
   end

   assign bus.dout       = dout_p1;
   assign bus.dout_ch    = ch_p1;
   assign bus.dout_valid = vld_p1;
   assign bus.scan_wrap  = wrap_p1;
endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: a directed vector table and hand-written sequences, then random
// stimulus against a list-based reference model, on a 4-channel and a 3-channel instance.
module tb_mux_scan;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        en_v   [2];
   logic        mode_v [2];
   logic [1:0]  sel_v  [2];
   logic [3:0]  mask_v [2];
   logic [31:0] din_v  [2];

   int m_dout [2];
   int m_ch   [2];
   int m_vld  [2];
   int m_wrap [2];
   int m_ptr  [2];

   localparam logic [31:0] DIN_D = 32'hD3C2B1A0;
   localparam logic [31:0] DIN_3 = 32'h00332211;

   mux_scan_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) bus4 ();
   mux_scan_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) bus3 ();

   assign bus4.en        = en_v[0];
   assign bus4.mode      = mode_v[0];
   assign bus4.sel       = sel_v[0];
   assign bus4.skip_mask = mask_v[0];
   assign bus4.din       = din_v[0];
   assign bus3.en        = en_v[1];
   assign bus3.mode      = mode_v[1];
   assign bus3.sel       = sel_v[1];
   assign bus3.skip_mask = mask_v[1][2:0];
   assign bus3.din       = din_v[1][23:0];

   mux_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   mux_scan #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   typedef struct {
      logic       en;
      logic       mode;
      logic [1:0] sel;
      logic [3:0] mask;
      int         e_dout;
      int         e_ch;
      int         e_vld;
      int         e_wrap;
      string      tag;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic en, logic mode, logic [1:0] sel, logic [3:0] mask,
                               int e_dout, int e_ch, int e_vld, int e_wrap, string tag);
      vec_t v;
      v.en = en; v.mode = mode; v.sel = sel; v.mask = mask;
      v.e_dout = e_dout; v.e_ch = e_ch; v.e_vld = e_vld; v.e_wrap = e_wrap; v.tag = tag;
      return v;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(int d, string tag, int e_dout, int e_ch, int e_vld, int e_wrap);
      int a_dout, a_ch, a_vld, a_wrap;
      a_dout = (d == 0) ? int'(bus4.dout)       : int'(bus3.dout);
      a_ch   = (d == 0) ? int'(bus4.dout_ch)    : int'(bus3.dout_ch);
      a_vld  = (d == 0) ? int'(bus4.dout_valid) : int'(bus3.dout_valid);
      a_wrap = (d == 0) ? int'(bus4.scan_wrap)  : int'(bus3.scan_wrap);
      check({tag, ".dout"},  a_dout, e_dout);
      check({tag, ".ch"},    a_ch,   e_ch);
      check({tag, ".valid"}, a_vld,  e_vld);
      check({tag, ".wrap"},  a_wrap, e_wrap);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_dout[d] = 0; m_ch[d] = 0; m_vld[d] = 0; m_wrap[d] = 0; m_ptr[d] = 0;
      end
   endtask

   // Reference: list the unmasked channels, take the first at or after the pointer,
   // otherwise the lowest one; the lap closes on the highest listed channel.
   task automatic model_step(int d);
      int nch, p, c;
      bit hit;
      int unm[$];
      nch = (d == 0) ? 4 : 3;
      if (!en_v[d]) begin
         m_vld[d] = 0; m_wrap[d] = 0;
         return;
      end
      if (!mode_v[d]) begin
         m_wrap[d] = 0;
         if (int'(sel_v[d]) < nch) begin
            m_dout[d] = int'((din_v[d] >> (8 * int'(sel_v[d]))) & 32'hFF);
            m_ch[d]   = int'(sel_v[d]);
            m_vld[d]  = 1;
         end else begin
            m_vld[d] = 0;
         end
         return;
      end
      p = (m_ptr[d] >= nch) ? 0 : m_ptr[d];
      for (int k = 0; k < nch; k++) if (!mask_v[d][k]) unm.push_back(k);
      if (unm.size() == 0) begin
         m_vld[d] = 0; m_wrap[d] = 0;
         return;
      end
      c = unm[0];
      hit = 1'b0;
      for (int j = 0; j < unm.size(); j++) begin
         if (!hit && unm[j] >= p) begin c = unm[j]; hit = 1'b1; end
      end
      m_dout[d] = int'((din_v[d] >> (8 * c)) & 32'hFF);
      m_ch[d]   = c;
      m_vld[d]  = 1;
      m_wrap[d] = (c == unm[unm.size() - 1]) ? 1 : 0;
      m_ptr[d]  = (c + 1) % nch;
   endtask

   task automatic drive(int d, logic en, logic mode, logic [1:0] sel, logic [3:0] mask,
                        logic [31:0] din);
      en_v[d] = en; mode_v[d] = mode; sel_v[d] = sel; mask_v[d] = mask; din_v[d] = din;
   endtask

   task automatic step();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0);
      model_reset();
      #12;
      check_outs(0, "reset4", 0, 0, 0, 0);
      check_outs(1, "reset3", 0, 0, 0, 0);
      #5 rst_n = 1'b1;

      // Scan two channels, then pull reset between edges.
      drive(0, 1'b1, 1'b1, 2'd0, 4'b0000, DIN_D);
      step(); check_outs(0, "prescan0", 'hA0, 0, 1, 0);
      step(); check_outs(0, "prescan1", 'hB1, 1, 1, 0);
      #3 rst_n = 1'b0;
      model_reset();
      #1 check_outs(0, "async_rst", 0, 0, 0, 0);
      step(); check_outs(0, "rst_held", 0, 0, 0, 0);
      #4 rst_n = 1'b1;

      tbl.push_back(mk(1, 1, 0, 4'b0000, 'hA0, 0, 1, 0, "scan_ch0"));
      tbl.push_back(mk(1, 1, 0, 4'b0000, 'hB1, 1, 1, 0, "scan_ch1"));
      tbl.push_back(mk(1, 1, 0, 4'b0000, 'hC2, 2, 1, 0, "scan_ch2"));
      tbl.push_back(mk(1, 1, 0, 4'b0000, 'hD3, 3, 1, 1, "scan_ch3"));
      tbl.push_back(mk(1, 1, 0, 4'b0000, 'hA0, 0, 1, 0, "scan_lap2"));
      tbl.push_back(mk(1, 0, 2, 4'b0000, 'hC2, 2, 1, 0, "man_sel2"));
      tbl.push_back(mk(0, 0, 2, 4'b0000, 'hC2, 2, 0, 0, "en_off_hold"));
      tbl.push_back(mk(1, 1, 0, 4'b0101, 'hB1, 1, 1, 0, "mask_ch1a"));
      tbl.push_back(mk(1, 1, 0, 4'b0101, 'hD3, 3, 1, 1, "mask_ch3a"));
      tbl.push_back(mk(1, 1, 0, 4'b0101, 'hB1, 1, 1, 0, "mask_ch1b"));
      tbl.push_back(mk(1, 1, 0, 4'b0101, 'hD3, 3, 1, 1, "mask_ch3b"));
      tbl.push_back(mk(1, 1, 0, 4'b1111, 'hD3, 3, 0, 0, "allmask1"));
      tbl.push_back(mk(1, 1, 0, 4'b1111, 'hD3, 3, 0, 0, "allmask2"));
      tbl.push_back(mk(1, 1, 0, 4'b1111, 'hD3, 3, 0, 0, "allmask3"));
      tbl.push_back(mk(1, 1, 0, 4'b1011, 'hC2, 2, 1, 1, "unmask_ch2"));
      tbl.push_back(mk(1, 1, 0, 4'b0000, 'hD3, 3, 1, 1, "resume_ch3"));
      tbl.push_back(mk(1, 1, 0, 4'b0000, 'hA0, 0, 1, 0, "sw_scan0"));
      tbl.push_back(mk(1, 1, 0, 4'b0000, 'hB1, 1, 1, 0, "sw_scan1"));
      tbl.push_back(mk(1, 0, 3, 4'b0000, 'hD3, 3, 1, 0, "sw_man3a"));
      tbl.push_back(mk(1, 0, 3, 4'b0000, 'hD3, 3, 1, 0, "sw_man3b"));
      tbl.push_back(mk(1, 1, 0, 4'b0000, 'hC2, 2, 1, 0, "sw_back2"));
      tbl.push_back(mk(1, 1, 0, 4'b0000, 'hD3, 3, 1, 1, "sw_back3"));
      tbl.push_back(mk(0, 1, 0, 4'b0000, 'hD3, 3, 0, 0, "scan_en_off"));
      tbl.push_back(mk(1, 1, 0, 4'b1110, 'hA0, 0, 1, 1, "single_ch0a"));
      tbl.push_back(mk(1, 1, 0, 4'b1110, 'hA0, 0, 1, 1, "single_ch0b"));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(0, tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].mask, DIN_D);
         step();
         check_outs(0, tbl[i].tag, tbl[i].e_dout, tbl[i].e_ch, tbl[i].e_vld, tbl[i].e_wrap);
      end

      for (int i = 0; i < 400; i++) begin
         drive(0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) < 7),
               2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
               $urandom);
         step();
         check_outs(0, "rnd4", m_dout[0], m_ch[0], m_vld[0], m_wrap[0]);
         if (i == 150) begin
            #2 rst_n = 1'b0;
            model_reset();
            #1 check_outs(0, "rnd4_rst", 0, 0, 0, 0);
            #1 rst_n = 1'b1;
         end
      end
      drive(0, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0);

      // Three-channel instance: select 3 is out of range, scan wraps after channel 2.
      drive(1, 1'b1, 1'b0, 2'd3, 4'b0000, DIN_3);
      step(); check_outs(1, "c3_sel3", 0, 0, 0, 0);
      drive(1, 1'b1, 1'b1, 2'd0, 4'b0000, DIN_3);
      step(); check_outs(1, "c3_scan0", 'h11, 0, 1, 0);
      step(); check_outs(1, "c3_scan1", 'h22, 1, 1, 0);
      step(); check_outs(1, "c3_scan2", 'h33, 2, 1, 1);
      step(); check_outs(1, "c3_scan0b", 'h11, 0, 1, 0);
      drive(1, 1'b1, 1'b0, 2'd3, 4'b0000, DIN_3);
      step(); check_outs(1, "c3_sel3_hold", 'h11, 0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         drive(1, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) < 7),
               2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 7)),
               $urandom & 32'h00FF_FFFF);
         step();
         check_outs(1, "rnd3", m_dout[1], m_ch[1], m_vld[1], m_wrap[1]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
